// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, one-outstanding imem requests, 2-entry return queue.
// Optional perf counters (perf_empty_cycles, perf_dropped) are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        FetchValidF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_empty_cycles,
    output logic [31:0] perf_dropped
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [1:0]  count_q, count_d;
    logic        outstanding_q, outstanding_d;
    logic        drop_q, drop_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;

    logic [31:0] fifo_inst_q [2];
    logic [31:0] fifo_pc_q   [2];

    logic        valid;
    logic        pop;
    logic        push;
    logic        accept;
    logic        inflight_after;
    logic [1:0]  count_next;
    logic [2:0]  credit_sum;

    always_comb begin
        valid          = (count_q != 2'd0);
        pop            = valid && !StallF;
        // A response is kept only if it belongs to the current path.
        push           = imem_rvalid && !drop_q && !PCSrcE;
        count_next     = count_q + {1'b0, push} - {1'b0, pop};
        inflight_after = outstanding_q && !imem_rvalid;
        credit_sum     = {1'b0, count_next} + {2'b00, inflight_after};
        imem_req       = !rst && !PCSrcE && (!outstanding_q || imem_rvalid)
                         && (credit_sum < 3'd2);
        imem_addr      = pc_q;
        accept         = imem_req && imem_ready;
    end

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        count_d       = count_next;
        rd_ptr_d      = rd_ptr_q ^ pop;
        wr_ptr_d      = wr_ptr_q ^ push;
        outstanding_d = accept || (outstanding_q && !imem_rvalid);
        drop_d        = drop_q && !imem_rvalid;
        if (accept) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end
        // Redirect flushes the queue; an unreturned request becomes wrong-path.
        if (PCSrcE) begin
            pc_d     = {PCTargetE[31:2], 2'b00};
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            drop_d   = outstanding_q && !imem_rvalid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            count_q       <= 2'd0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue payload needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    always_comb begin
        FetchValidF = valid;
        InstF       = valid ? fifo_inst_q[rd_ptr_q] : NOP_INST;
        PCF         = valid ? fifo_pc_q[rd_ptr_q] : 32'd0;
        PCPlus4F    = PCF + 32'd4;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count_q == 2'd2));

`ifdef FETCH_PERF_CNT_EN
    logic [1:0] perf_inc;

    always_comb begin
        perf_inc[0] = !valid && !StallF && !PCSrcE;
        perf_inc[1] = imem_rvalid && (drop_q || PCSrcE);
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        logic [31:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (perf_inc[gi] && cnt_q != 32'hFFFF_FFFF) begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= 32'd0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign perf_empty_cycles = g_perf[0].cnt_q;
    assign perf_dropped      = g_perf[1].cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory model, queue/epoch reference model, directed scenarios.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] InstF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        FetchValidF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_empty_cycles;
    logic [31:0] perf_dropped;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstF(InstF), .PCF(PCF), .PCPlus4F(PCPlus4F), .FetchValidF(FetchValidF)
`ifdef FETCH_PERF_CNT_EN
        , .perf_empty_cycles(perf_empty_cycles), .perf_dropped(perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Memory model state (owned by the stimulus process)
    int          lat = 1;
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] resp_addr = 32'd0;

    // Reference model state (owned by the compare process)
    logic [31:0] q[$];
    int          epoch = 0;
    int          req_epoch = -1;
    logic [31:0] exp_req = RESET_PC;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: wrong-path responses are those whose request epoch is stale.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            q.delete();
            epoch++;
            exp_req = RESET_PC;
        end else begin
            chk("valid", 32'(FetchValidF), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("pcf", PCF, q[0]);
                chk("inst", InstF, memf(q[0]));
                chk("pcplus4", PCPlus4F, q[0] + 32'd4);
            end else begin
                chk("nop_inst", InstF, NOP);
                chk("nop_pcf", PCF, 32'd0);
                chk("nop_pcplus4", PCPlus4F, 32'd4);
            end
            if (PCSrcE) chk("req_on_redirect", 32'(imem_req), 32'd0);
            if (imem_req && imem_ready) chk("req_addr", imem_addr, exp_req);
            if (PCSrcE) begin
                q.delete();
                epoch++;
                exp_req = {PCTargetE[31:2], 2'b00};
            end else begin
                if (q.size() != 0 && !StallF) begin
                    $display("[TB] pop pc=%h inst=%h", PCF, InstF);
                    void'(q.pop_front());
                end
                if (imem_rvalid && req_epoch == epoch) q.push_back(resp_addr);
                if (imem_req && imem_ready) begin
                    req_epoch = epoch;
                    exp_req   = exp_req + 32'd4;
                end
            end
        end
    end

    task automatic step(input logic stall, input logic redir, input logic [31:0] tgt,
                        input logic rdy);
        @(negedge clk);
        StallF     = stall;
        PCSrcE     = redir;
        PCTargetE  = tgt;
        imem_ready = rdy;
        if (mem_busy && mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            resp_addr   = mem_addr;
            imem_rdata  = memf(mem_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        if (imem_rvalid) mem_busy = 0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
        if (imem_req && imem_ready) begin
            mem_busy = 1;
            mem_addr = imem_addr;
            mem_cnt  = lat - 1;
        end
    endtask

    task automatic hold_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
        mem_busy = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(FetchValidF), 32'd0);
        chk({tag, "_inst"}, InstF, NOP);
        chk({tag, "_pcf"}, PCF, 32'd0);
        chk({tag, "_pcplus4"}, PCPlus4F, 32'd4);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
    endtask

    initial begin
        logic [31:0] rec;
        int nv, na, guard;
        bit found;

        // 1: reset, single-cycle memory, back-to-back fetch
        lat = 1;
        hold_reset();
        check_reset_outputs("rst");
        rst = 1'b0;
        step(0, 0, 0, 1);
        chk("t1_req0", 32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        step(0, 0, 0, 1);
        chk("t1_addr1", imem_addr, 32'h4);
        step(0, 0, 0, 1);
        chk("t1_valid2", 32'(FetchValidF), 32'd1);
        chk("t1_pcf2", PCF, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("t1_perf_empty", perf_empty_cycles, 32'd2);
`endif
        step(0, 0, 0, 1);
        chk("t1_pcf3", PCF, 32'h4);
        step(0, 0, 0, 1);
        chk("t1_pcf4", PCF, 32'h8);
        chk("t1_pcplus4", PCPlus4F, 32'hC);

        // 2: three-cycle memory -> accepts at 0,3,6,9; valid at 4,7,10
        lat = 3;
        hold_reset();
        rst = 1'b0;
        nv = 0; na = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1);
            if (FetchValidF) nv++;
            if (imem_req && imem_ready) na++;
        end
        chk("t2_valid_cycles", 32'(nv), 32'd3);
        chk("t2_accepts", 32'(na), 32'd4);

        // 3: stall fills the queue and holds the head
        lat = 1;
        hold_reset();
        rst = 1'b0;
        repeat (6) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("t3_valid", 32'(FetchValidF), 32'd1);
        rec = PCF;
        repeat (4) step(1, 0, 0, 1);
        chk("t3_req_off", 32'(imem_req), 32'd0);
        chk("t3_head_stable", PCF, rec);
        step(0, 0, 0, 1);
        chk("t3_release0", PCF, rec);
        step(0, 0, 0, 1);
        chk("t3_release1", PCF, rec + 32'd4);
        repeat (4) step(0, 0, 0, 1);

        // 4: redirect while the 0x20 request is in flight
        lat = 3;
        hold_reset();
        rst = 1'b0;
        found = 0; guard = 0;
        while (!found && guard < 60) begin
            step(0, 0, 0, 1);
            if (imem_req && imem_ready && imem_addr == 32'h20) found = 1;
            guard++;
        end
        chk("t4_saw_0x20", 32'(found), 32'd1);
        step(0, 1, 32'h100, 1);
        found = 0; guard = 0;
        while (!found && guard < 20) begin
            step(0, 0, 0, 1);
            if (imem_req && imem_ready) begin
                chk("t4_next_addr", imem_addr, 32'h100);
                found = 1;
            end
            guard++;
        end
        chk("t4_next_req_seen", 32'(found), 32'd1);
        found = 0; guard = 0;
        while (!found && guard < 20) begin
            step(0, 0, 0, 1);
            if (FetchValidF) begin
                chk("t4_first_pcf", PCF, 32'h100);
                found = 1;
            end
            guard++;
        end
        chk("t4_valid_seen", 32'(found), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("t4_perf_dropped", perf_dropped, 32'd1);
`endif
        repeat (4) step(0, 0, 0, 1);

        // 5: redirect in the same cycle a response returns into an occupied queue
        lat = 1;
        hold_reset();
        rst = 1'b0;
        repeat (6) step(0, 0, 0, 1);
        step(1, 1, 32'h200, 1);
        step(0, 0, 0, 1);
        chk("t5_empty", 32'(FetchValidF), 32'd0);
        chk("t5_req", 32'(imem_req), 32'd1);
        chk("t5_addr", imem_addr, 32'h200);
        repeat (6) step(0, 0, 0, 1);

        // 6: asynchronous reset with a full queue
        lat = 1;
        hold_reset();
        rst = 1'b0;
        repeat (4) step(0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 1);
        chk("t6_full_valid", 32'(FetchValidF), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1; imem_rvalid = 1'b0; mem_busy = 0;
        #1;
        check_reset_outputs("t6_async");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0, 1);
        chk("t6_restart_req", 32'(imem_req), 32'd1);
        chk("t6_restart_addr", imem_addr, RESET_PC);
        repeat (4) step(0, 0, 0, 1);

        // 7: two-cycle memory with irregular ready, stalls and a redirect (model-checked)
        lat = 2;
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 3) == 0), (i == 20), 32'h0000_0400,
                 ($urandom_range(0, 2) != 0));
        end
        repeat (6) step(0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
